// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared types and constants for the UART receiver front end.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int unsigned c_DATA_WIDTH_DEFAULT = 8;

    localparam int unsigned c_PRESCALE_8       = 8;
    localparam int unsigned c_PRESCALE_16      = 16;
    localparam int unsigned c_PRESCALE_32      = 32;
    localparam int unsigned c_PRESCALE_DEFAULT = c_PRESCALE_8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Unsupported oversampling ratios fall back to the default ratio.
    function automatic int unsigned legal_prescale(input int unsigned p);
        if (p == c_PRESCALE_16 || p == c_PRESCALE_32) begin
            return p;
        end
        return c_PRESCALE_DEFAULT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : Per-bit oversampling counter with 3-sample majority vote.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_val,
    output logic                  bit_done,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [2:0]            r_samples;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_last;

    assign w_half = prescale >> 1;
    assign w_last = prescale - PRESCALE_W'(1);

    assign bit_end  = run && (r_edge_cnt == w_last);
    assign bit_done = run && (r_edge_cnt == w_half + PRESCALE_W'(2));

    // All three samples are settled once the counter reaches P/2+2.
    assign bit_val = (r_samples[0] & r_samples[1]) |
                     (r_samples[1] & r_samples[2]) |
                     (r_samples[0] & r_samples[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_samples  <= '0;
        end else if (!run) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= bit_end ? '0 : r_edge_cnt + PRESCALE_W'(1);
            if (r_edge_cnt == w_half - PRESCALE_W'(1)) begin
                r_samples[0] <= rx;
            end
            if (r_edge_cnt == w_half) begin
                r_samples[1] <= rx;
            end
            if (r_edge_cnt == w_half + PRESCALE_W'(1)) begin
                r_samples[2] <= rx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : UART receiver: frame FSM, parity/stop checks, flag pulses.
//            Define UART_RX_SYNC_EN to add a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int c_BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(DATA_WIDTH - 1);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_rx_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], RX_IN};
        end
    end

    assign w_rx = r_rx_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    rx_state_t             r_state,      w_state_nxt;
    logic [PRESCALE_W-1:0] r_prescale,   w_prescale_nxt;
    logic [c_BCW-1:0]      r_bit_cnt,    w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data,       w_data_nxt;
    logic                  r_par_en,     w_par_en_nxt;
    logic                  r_par_typ,    w_par_typ_nxt;
    logic                  r_par_fail,   w_par_fail_nxt;
    logic                  r_data_valid, w_data_valid_nxt;
    logic                  r_par_err,    w_par_err_nxt;
    logic                  r_stp_err,    w_stp_err_nxt;

    logic w_run;
    logic w_bit_val;
    logic w_bit_done;
    logic w_bit_end;
    logic w_par_exp;

    assign w_run     = (r_state != IDLE);
    assign w_par_exp = (^r_data) ^ r_par_typ;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx       (w_rx),
        .run      (w_run),
        .prescale (r_prescale),
        .bit_val  (w_bit_val),
        .bit_done (w_bit_done),
        .bit_end  (w_bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_prescale   <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_fail   <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prescale   <= w_prescale_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_data       <= w_data_nxt;
            r_par_en     <= w_par_en_nxt;
            r_par_typ    <= w_par_typ_nxt;
            r_par_fail   <= w_par_fail_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_par_err    <= w_par_err_nxt;
            r_stp_err    <= w_stp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_prescale_nxt   = r_prescale;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_data_nxt       = r_data;
        w_par_en_nxt     = r_par_en;
        w_par_typ_nxt    = r_par_typ;
        w_par_fail_nxt   = r_par_fail;
        w_data_valid_nxt = 1'b0;
        w_par_err_nxt    = 1'b0;
        w_stp_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_state_nxt    = START;
                    w_prescale_nxt = PRESCALE_W'(legal_prescale(32'(Prescale)));
                    w_bit_cnt_nxt  = '0;
                end
            end
            START: begin
                if (w_bit_done && w_bit_val) begin
                    w_state_nxt = IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                    w_par_en_nxt  = PAR_EN;
                    w_par_typ_nxt = PAR_TYP;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_data_nxt[r_bit_cnt] = w_bit_val;
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_done && (w_bit_val != w_par_exp)) begin
                    w_par_fail_nxt = 1'b1;
                end
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Decide mid-bit so the next start edge is never missed.
                if (w_bit_done) begin
                    if (!w_bit_val) begin
                        w_stp_err_nxt = 1'b1;
                    end else if (r_par_fail) begin
                        w_par_err_nxt = 1'b1;
                    end else begin
                        w_data_valid_nxt = 1'b1;
                    end
                    w_par_fail_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign P_DATA     = r_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire
